// File: rtl/player_kbd_ctrl.sv
// player_kbd_ctrl
//   PS/2 keyboard front end for the player register. Receives PS/2 frames,
//   decodes extended make/break codes for Up-arrow (forward, E0 75) and
//   Right-arrow (rotate, E0 74), tracks which keys are held and issues
//   one-cycle movement strobes once per movement tick while a key is held.
//
// Ports
//   clk        system clock
//   reset      asynchronous active-high reset
//   ps2_clk    raw PS/2 clock pin (asynchronous)
//   ps2_dat    raw PS/2 data pin (asynchronous)
//   forward    one-cycle strobe per tick while forward key held
//   rotate     one-cycle strobe per tick while rotate key held
//   fwd_held   forward key currently held
//   rot_held   rotate key currently held
//   frame_err  one-cycle pulse on parity/stop/timeout error
module player_kbd_ctrl #(
   parameter int TICK_DIV = 833333,
   parameter int TIMEOUT  = 10000,
   parameter int CNT_W    = 20
) (
   input  logic clk,
   input  logic reset,
   input  logic ps2_clk,
   input  logic ps2_dat,
   output logic forward,
   output logic rotate,
   output logic fwd_held,
   output logic rot_held,
   output logic frame_err
);

   typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} rx_state_t;

   rx_state_t        state_q, state_d;
   logic [1:0]       clk_sync_q, clk_sync_d;
   logic [1:0]       dat_sync_q, dat_sync_d;
   logic             clk_prev_q, clk_prev_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [8:0]       shift_q, shift_d;
   logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
   logic [7:0]       byte_q, byte_d;
   logic             byte_valid_q, byte_valid_d;
   logic             frame_err_q, frame_err_d;
   logic             ext_q, ext_d;
   logic             brk_q, brk_d;
   logic             fwd_held_q, fwd_held_d;
   logic             rot_held_q, rot_held_d;
   logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
   logic             forward_q, forward_d;
   logic             rotate_q, rotate_d;

   logic       fall;
   logic       bit_in;
   logic [9:0] frame_full;
   logic       last_edge;
   logic       timed_out;
   logic       frame_ok;
   logic       tick_wrap;

   // Synchronizers idle at 1 so reset does not fabricate a falling edge.
   always_comb begin
      clk_sync_d = {clk_sync_q[0], ps2_clk};
      dat_sync_d = {dat_sync_q[0], ps2_dat};
      clk_prev_d = clk_sync_q[1];
      fall       = clk_prev_q & ~clk_sync_q[1];
      bit_in     = dat_sync_q[1];
      // {stop, parity, D7..D0} as seen on the 11th edge
      frame_full = {bit_in, shift_q};
      // bit_cnt counts edges already taken; the 11th edge arrives at 10
      last_edge  = (state_q == ST_SHIFT) && fall && (bit_cnt_q == 4'd10);
      timed_out  = (state_q == ST_SHIFT) && !fall && (to_cnt_q == CNT_W'(TIMEOUT));
      frame_ok   = frame_full[9] & (^frame_full[8:0]);
   end

   // Receiver FSM: state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Receiver FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (fall && !bit_in)        state_d = ST_SHIFT;
         ST_SHIFT: if (last_edge || timed_out) state_d = ST_IDLE;
         default:                              state_d = ST_IDLE;
      endcase
   end

   // Receiver FSM: outputs and bit datapath
   always_comb begin
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      to_cnt_d     = to_cnt_q;
      byte_d       = byte_q;
      byte_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            to_cnt_d = '0;
            if (fall && !bit_in) begin
               bit_cnt_d = 4'd1;
               shift_d   = '0;
            end
         end
         ST_SHIFT: begin
            if (fall) begin
               // LSB first: shifting right leaves D0 at bit 0 after 9 shifts
               shift_d   = frame_full[9:1];
               bit_cnt_d = bit_cnt_q + 4'd1;
               to_cnt_d  = '0;
            end else if (timed_out) begin
               to_cnt_d = '0;
            end else begin
               to_cnt_d = to_cnt_q + CNT_W'(1);
            end
            if (last_edge) begin
               byte_d       = shift_q[7:0];
               byte_valid_d = frame_ok;
               frame_err_d  = ~frame_ok;
            end
            if (timed_out) frame_err_d = 1'b1;
         end
         default: ;
      endcase
   end

   // Decoder: E0/F0 prefixes persist until the next non-prefix byte, so
   // both E0 F0 xx and F0 E0 xx are valid breaks.
   always_comb begin
      ext_d      = ext_q;
      brk_d      = brk_q;
      fwd_held_d = fwd_held_q;
      rot_held_d = rot_held_q;
      if (byte_valid_q) begin
         case (byte_q)
            8'hE0: ext_d = 1'b1;
            8'hF0: brk_d = 1'b1;
            default: begin
               if (ext_q) begin
                  if (byte_q == 8'h75) fwd_held_d = ~brk_q;
                  if (byte_q == 8'h74) rot_held_d = ~brk_q;
               end
               ext_d = 1'b0;
               brk_d = 1'b0;
            end
         endcase
      end
   end

   // Tick generator: strobes sample the held flags before any update
   // landing in the same cycle.
   always_comb begin
      tick_wrap  = (tick_cnt_q == CNT_W'(TICK_DIV - 1));
      tick_cnt_d = tick_wrap ? '0 : tick_cnt_q + CNT_W'(1);
      forward_d  = tick_wrap & fwd_held_q;
      rotate_d   = tick_wrap & rot_held_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_sync_q   <= 2'b11;
         dat_sync_q   <= 2'b11;
         clk_prev_q   <= 1'b1;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         to_cnt_q     <= '0;
         byte_q       <= '0;
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         ext_q        <= 1'b0;
         brk_q        <= 1'b0;
         fwd_held_q   <= 1'b0;
         rot_held_q   <= 1'b0;
         tick_cnt_q   <= '0;
         forward_q    <= 1'b0;
         rotate_q     <= 1'b0;
      end else begin
         clk_sync_q   <= clk_sync_d;
         dat_sync_q   <= dat_sync_d;
         clk_prev_q   <= clk_prev_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         to_cnt_q     <= to_cnt_d;
         byte_q       <= byte_d;
         byte_valid_q <= byte_valid_d;
         frame_err_q  <= frame_err_d;
         ext_q        <= ext_d;
         brk_q        <= brk_d;
         fwd_held_q   <= fwd_held_d;
         rot_held_q   <= rot_held_d;
         tick_cnt_q   <= tick_cnt_d;
         forward_q    <= forward_d;
         rotate_q     <= rotate_d;
      end
   end

   assign forward   = forward_q;
   assign rotate    = rotate_q;
   assign fwd_held  = fwd_held_q;
   assign rot_held  = rot_held_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_player_kbd_ctrl.sv
// tb_player_kbd_ctrl
//   Drives PS/2 frames into player_kbd_ctrl. The stimulus side keeps a
//   key-level model (prefix flags and held keys) and queues the events each
//   frame should produce; a separate monitor pops an entry whenever the DUT
//   raises frame_err or changes a held flag, and checks every tick strobe
//   against the held state it has tracked from those expectations.
module tb_player_kbd_ctrl;
   localparam int TICK_DIV = 16;
   localparam int TIMEOUT  = 64;
   localparam int CNT_W    = 8;
   localparam int HALF_BIT = 10;

   logic clk = 1'b0;
   logic reset;
   logic ps2_clk;
   logic ps2_dat;
   logic forward, rotate, fwd_held, rot_held, frame_err;

   player_kbd_ctrl #(.TICK_DIV(TICK_DIV), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
      .forward(forward), .rotate(rotate), .fwd_held(fwd_held),
      .rot_held(rot_held), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit is_err;
      bit is_to;
      bit fwd;
      bit rot;
   } ev_t;

   ev_t exp_q[$];
   int  vectors = 0;
   int  miscompares = 0;
   int  cyc = 0;
   int  n_tick = 0;
   int  last_fall_cyc = 0;
   bit  m_ext, m_brk, m_fwd, m_rot;

   task automatic check(input string nm, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   // Cycle counters: n_tick counts clock edges since reset was last released.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         if (reset) n_tick = 0;
         else       n_tick++;
      end
   end

   // Key-level reference: what a byte does to the prefix flags and held keys.
   task automatic model_byte(input logic [7:0] b);
      ev_t e;
      bit  of, orr;
      of  = m_fwd;
      orr = m_rot;
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else begin
         if (m_ext && b == 8'h75) m_fwd = !m_brk;
         if (m_ext && b == 8'h74) m_rot = !m_brk;
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
      if (of != m_fwd || orr != m_rot) begin
         e.is_err = 1'b0; e.is_to = 1'b0; e.fwd = m_fwd; e.rot = m_rot;
         exp_q.push_back(e);
      end
   endtask

   task automatic push_err(input bit to);
      ev_t e;
      e.is_err = 1'b1; e.is_to = to; e.fwd = 1'b0; e.rot = 1'b0;
      exp_q.push_back(e);
   endtask

   // Drives the first nedges bits of a frame; the receiver samples on the
   // falling edge, data changes while ps2_clk is high.
   task automatic drive_bits(input logic [10:0] fb, input int nedges);
      for (int i = 0; i < nedges; i++) begin
         @(negedge clk);
         ps2_dat = fb[i];
         repeat (HALF_BIT - 1) @(negedge clk);
         ps2_clk = 1'b0;
         last_fall_cyc = cyc;
         repeat (HALF_BIT) @(negedge clk);
         ps2_clk = 1'b1;
      end
      @(negedge clk);
      ps2_dat = 1'b1;
   endtask

   function automatic logic [10:0] build(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      logic p;
      p = ~(^b);
      if (bad_par) p = ~p;
      return {~bad_stop, p, b, 1'b0};
   endfunction

   task automatic send(input logic [7:0] b, input bit bad_par = 1'b0, input bit bad_stop = 1'b0);
      if (bad_par || bad_stop) push_err(1'b0);
      else model_byte(b);
      drive_bits(build(b, bad_par, bad_stop), 11);
      repeat ($urandom_range(8, 30)) @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: samples 1 time unit after the falling clock edge.
   initial begin
      bit  mf, mr, pf, pr, prev_f, prev_r, tick_now;
      ev_t e;
      int  d;
      mf = 0; mr = 0; prev_f = 0; prev_r = 0;
      forever begin
         @(negedge clk);
         #1;
         if (reset) begin
            exp_q.delete();
            mf = 0; mr = 0; prev_f = 0; prev_r = 0;
         end else begin
            pf = mf;
            pr = mr;
            if (frame_err === 1'b1) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_frame_err", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("frame_err_event", 1, int'(e.is_err));
                  if (e.is_to) begin
                     d = cyc - last_fall_cyc;
                     check("timeout_latency_in_window", int'(d >= TIMEOUT - 2 && d <= TIMEOUT + 10), 1);
                  end
               end
            end
            if (fwd_held !== prev_f || rot_held !== prev_r) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_held_change", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("held_event_kind", int'(e.is_err), 0);
                  check("fwd_held", int'(fwd_held), int'(e.fwd));
                  check("rot_held", int'(rot_held), int'(e.rot));
                  mf = e.fwd;
                  mr = e.rot;
               end
            end
            prev_f = fwd_held;
            prev_r = rot_held;
            tick_now = (n_tick > 0) && (n_tick % TICK_DIV == 0);
            if (tick_now || forward !== 1'b0 || rotate !== 1'b0) begin
               check("forward_strobe", int'(forward === 1'b1), int'(tick_now && pf));
               check("rotate_strobe", int'(rotate === 1'b1), int'(tick_now && pr));
            end
         end
      end
   end

   initial begin
      logic [7:0] rb;
      int         sel;
      m_ext = 0; m_brk = 0; m_fwd = 0; m_rot = 0;
      reset = 1'b1;
      ps2_clk = 1'b1;
      ps2_dat = 1'b1;
      idle(3);
      check("rst_forward", int'(forward), 0);
      check("rst_rotate", int'(rotate), 0);
      check("rst_fwd_held", int'(fwd_held), 0);
      check("rst_rot_held", int'(rot_held), 0);
      check("rst_frame_err", int'(frame_err), 0);
      reset = 1'b0;
      idle(5);

      // forward press, hold for a few ticks, then release
      send(8'hE0); send(8'h75); idle(70);
      send(8'hE0); send(8'hF0); send(8'h75); idle(40);

      // both keys, then break rotate with F0 before E0
      send(8'hE0); send(8'h74); send(8'hE0); send(8'h75); idle(70);
      send(8'hF0); send(8'hE0); send(8'h74); idle(50);

      // parity error leaves state alone, following frames decode normally
      send(8'h75, 1'b1, 1'b0); idle(10);
      send(8'hE0); send(8'hF0); send(8'h75); idle(30);
      send(8'hE0, 1'b0, 1'b1); idle(10);

      // partial frame then silence -> timeout
      push_err(1'b1);
      drive_bits(build(8'hE0, 1'b0, 1'b0), 5);
      idle(80);
      send(8'hE0); send(8'h75); idle(40);

      // non-extended 75 is ignored
      send(8'h75); idle(40);

      // reset in the middle of an E0 frame
      drive_bits(build(8'hE0, 1'b0, 1'b0), 5);
      reset = 1'b1;
      ps2_clk = 1'b1;
      ps2_dat = 1'b1;
      m_ext = 0; m_brk = 0; m_fwd = 0; m_rot = 0;
      #1;
      check("midrst_fwd_held", int'(fwd_held), 0);
      check("midrst_rot_held", int'(rot_held), 0);
      check("midrst_forward", int'(forward), 0);
      check("midrst_frame_err", int'(frame_err), 0);
      idle(3);
      reset = 1'b0;
      idle(5);
      send(8'hE0); send(8'h74); idle(40);
      check("after_rst_rot_held", int'(rot_held), 1);

      // random traffic: prefixes, key codes, other bytes, occasional errors
      for (int i = 0; i < 40; i++) begin
         sel = $urandom_range(0, 9);
         case (sel)
            0, 1, 2: rb = 8'hE0;
            3, 4:    rb = 8'hF0;
            5, 6:    rb = 8'h75;
            7:       rb = 8'h74;
            default: rb = 8'($urandom);
         endcase
         if ($urandom_range(0, 7) == 0) send(rb, 1'b1, 1'b0);
         else if ($urandom_range(0, 15) == 0) send(rb, 1'b0, 1'b1);
         else send(rb);
      end
      idle(60);

      check("queue_drained", exp_q.size(), 0);
      check("final_fwd_held", int'(fwd_held), int'(m_fwd));
      check("final_rot_held", int'(rot_held), int'(m_rot));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
